// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator gate counter.
package ro_pkg;

    // Measurement FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } ro_state_t;

    // Default measurement window length in clk cycles.
    localparam int GATE_CYCLES_DEFAULT = 10000;

endpackage

// File: rtl/sync2.sv
// Parameterised flop-chain synchroniser; every stage resets to 0.
module sync2 #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous input through the chain, one stage per clk.
    // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ro_gate_counter.sv
// Counts rising edges of an asynchronous ring-oscillator output over a
// fixed window of GATE_CYCLES clk cycles and publishes the saturating result.
module ro_gate_counter
    import ro_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int               TW         = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ACC_MAX    = '1;

    ro_state_t        state_q;
    logic [TW-1:0]    timer_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic             sat_q;
    logic             sat_next;
    logic             sync_q;
    logic             hist_q;
    logic             rise;

    // Synchroniser runs in every state so the history flop always holds the
    // previous level and a steady high input never looks like an edge.
    sync2 #(
        .STAGES (2),
        .WIDTH  (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (osc_in),
        .q     (sync_q)
    );

    // History flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q;
        end
    end

    assign rise = sync_q & ~hist_q;

    // Saturating accumulator step: at the maximum, an edge sets the flag instead of wrapping.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_next = acc_q;
        sat_next = sat_q;
        if (rise) begin
            if (acc_q == ACC_MAX) begin
                sat_next = 1'b1;
            end else begin
                acc_next = acc_q + WIDTH'(1);
            end
        end
    end

    // Gate FSM with registered outputs; the result is loaded on the edge that
    // enters DONE, so count/overflow/count_valid are visible during DONE and
    // the final gate cycle's edge is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= GATE;
                        timer_q <= '0;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                GATE: begin
                    if (!en) begin
                        // Abort: drop the partial window, keep the published result.
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        acc_q <= acc_next;
                        sat_q <= sat_next;
                        if (timer_q == TIMER_LAST) begin
                            state_q     <= DONE;
                            busy        <= 1'b0;
                            count       <= acc_next;
                            overflow    <= sat_next;
                            count_valid <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                DONE: begin
                    if (en) begin
                        state_q <= GATE;
                        timer_q <= '0;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
